// File: rtl/bus_pkg.sv
// Shared definitions for the main-bus arbiter: default widths, peripheral
// selector codes (address bits [15:12]) and the arbiter state encoding.
package bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 256;

    typedef enum logic [3:0] {
        PERIPH_RAM = 4'd0,
        PERIPH_REG = 4'd1,
        PERIPH_ROM = 4'd2,
        PERIPH_MAT = 4'd3,
        PERIPH_INT = 4'd5
    } periph_sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side request/strobe bundle and arbiter-side grant/peripheral bundle.
// The tri-state main bus itself stays a plain inout on the arbiter.
interface bus_arbiter_if
    import bus_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = bus_pkg::ADDR_W,
    parameter int DATA_W  = bus_pkg::DATA_W
);
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0][ADDR_W-1:0] m_addr;
    logic [NUM_REQ-1:0]             m_nRead;
    logic [NUM_REQ-1:0]             m_nWrite;
    logic [NUM_REQ-1:0][DATA_W-1:0] m_wdata;

    logic [NUM_REQ-1:0]             gnt;
    logic [1:0]                     owner;
    logic                           busy;
    logic [ADDR_W-1:0]              addr;
    logic                           nRead;
    logic                           nWrite;
    logic [DATA_W-1:0]              rdata;

    modport slave (
        input  req, m_addr, m_nRead, m_nWrite, m_wdata,
        output gnt, owner, busy, addr, nRead, nWrite, rdata
    );

    modport master (
        output req, m_addr, m_nRead, m_nWrite, m_wdata,
        input  gnt, owner, busy, addr, nRead, nWrite, rdata
    );
endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after i_last, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [1:0]         i_last,
    output logic               o_found,
    output logic [1:0]         o_idx
);
    logic       w_hi_found;
    logic       w_lo_found;
    logic [1:0] w_hi_idx;
    logic [1:0] w_lo_idx;

    // Lowest requester above i_last wins; otherwise wrap to the lowest overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = 2'd0;
        w_lo_idx   = 2'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                if (i > int'(i_last)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = 2'(i);
                end else begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = 2'(i);
                end
            end
        end
    end

    assign o_found = w_hi_found | w_lo_found;
    assign o_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared main bus with a one-cycle turnaround.
// Optional pre-emption after MAX_BURST grant cycles: define BUS_ARB_BURST_LIMIT_EN.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = bus_pkg::ADDR_W,
    parameter int DATA_W    = bus_pkg::DATA_W,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              Reset,
    bus_arbiter_if.slave      bif,
    inout  wire  [DATA_W-1:0] bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 4 || MAX_BURST < 1) begin : g_param_err
        $error("bus_arbiter: NUM_REQ must be 2..4 and MAX_BURST >= 1");
    end

    arb_state_t         r_state;
    arb_state_t         w_state_nx;
    logic [1:0]         r_owner;
    logic [1:0]         w_owner_nx;
    logic [1:0]         r_last;
    logic [1:0]         w_last_nx;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] w_gnt_nx;

    logic               w_found;
    logic [1:0]         w_idx;
    logic               w_owner_req;
    logic               w_busy;
    logic               w_drive;
    logic [IDX_W-1:0]   w_sel;
    logic [ADDR_W-1:0]  w_addr;

`ifdef BUS_ARB_BURST_LIMIT_EN
    localparam int               CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] r_burst_cnt;
    logic [CNT_W-1:0] w_burst_cnt_nx;
    logic             w_others;

    assign w_others = |(bif.req & ~r_gnt);
`endif

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .i_req   (bif.req),
        .i_last  (r_last),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    // r_gnt is one-hot of the owner while granted, so it doubles as a mask.
    assign w_owner_req = |(bif.req & r_gnt);

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_owner     <= 2'd0;
            r_last      <= 2'(NUM_REQ - 1);
            r_gnt       <= '0;
`ifdef BUS_ARB_BURST_LIMIT_EN
            r_burst_cnt <= '0;
`endif
        end else begin
            r_state     <= w_state_nx;
            r_owner     <= w_owner_nx;
            r_last      <= w_last_nx;
            r_gnt       <= w_gnt_nx;
`ifdef BUS_ARB_BURST_LIMIT_EN
            r_burst_cnt <= w_burst_cnt_nx;
`endif
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_owner_nx     = r_owner;
        w_last_nx      = r_last;
        w_gnt_nx       = r_gnt;
`ifdef BUS_ARB_BURST_LIMIT_EN
        w_burst_cnt_nx = r_burst_cnt;
`endif
        case (r_state)
            IDLE, TURN: begin
                if (w_found) begin
                    w_state_nx     = GRANT;
                    w_owner_nx     = w_idx;
                    w_last_nx      = w_idx;
                    w_gnt_nx       = NUM_REQ'(1) << w_idx;
`ifdef BUS_ARB_BURST_LIMIT_EN
                    w_burst_cnt_nx = '0;
`endif
                end else begin
                    w_state_nx = IDLE;
                    w_gnt_nx   = '0;
                end
            end
            GRANT: begin
                // A release wins over pre-emption when both happen together.
                if (!w_owner_req) begin
                    w_state_nx = TURN;
                    w_gnt_nx   = '0;
                end
`ifdef BUS_ARB_BURST_LIMIT_EN
                else if (r_burst_cnt == CNT_LAST) begin
                    if (w_others) begin
                        w_state_nx = TURN;
                        w_gnt_nx   = '0;
                    end
                end else begin
                    w_burst_cnt_nx = r_burst_cnt + 1'b1;
                end
`endif
            end
            default: begin
                w_state_nx = IDLE;
                w_gnt_nx   = '0;
            end
        endcase
    end

    // Peripheral side is steered only by registered ownership, never by req.
    assign w_busy  = (r_state == GRANT);
    assign w_sel   = r_owner[IDX_W-1:0];
    assign w_addr  = w_busy ? bif.m_addr[w_sel] : '0;
    assign w_drive = w_busy & ~bif.m_nWrite[w_sel];

    assign bif.gnt    = r_gnt;
    assign bif.owner  = r_owner;
    assign bif.busy   = w_busy;
    assign bif.addr   = w_addr;
    assign bif.nRead  = w_busy ? bif.m_nRead[w_sel]  : 1'b1;
    assign bif.nWrite = w_busy ? bif.m_nWrite[w_sel] : 1'b1;

    assign bus       = w_drive ? bif.m_wdata[w_sel] : {DATA_W{1'bz}};
    assign bif.rdata = bus;
endmodule
